// File: rtl/pp_block_deinterleaver_pkg.sv
// pp_deint_pkg: shared definitions for the ping-pong block deinterleaver.
//   - frame length and storage address width helpers
//   - mode encoding (MODE_DEINT / MODE_INT)
//   - read-side state enum
package pp_deint_pkg;

    localparam logic MODE_DEINT = 1'b0;
    localparam logic MODE_INT   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rd_state_t;

    function automatic int calc_depth(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Bank bit plus in-bank address.
    function automatic int calc_addr_w(input int depth);
        return $clog2(2 * depth);
    endfunction

endpackage

// File: rtl/pp_block_deinterleaver_if.sv
// pp_block_deinterleaver_if: symbol stream bundle for the block deinterleaver.
//   data_in/en_in/sof_in/mode_in     : input stream (no backpressure)
//   deleav_data/en_out/sof_out       : permuted output stream
//   frame_err                        : short-frame pulse
// Modports: slave = the deinterleaver, master = the stream source/sink.
interface pp_block_deinterleaver_if #(
    parameter int DATA_W = 11
);
    logic [DATA_W-1:0] data_in;
    logic              en_in;
    logic              sof_in;
    logic              mode_in;
    logic [DATA_W-1:0] deleav_data;
    logic              en_out;
    logic              sof_out;
    logic              frame_err;

    modport slave (
        input  data_in, en_in, sof_in, mode_in,
        output deleav_data, en_out, sof_out, frame_err
    );

    modport master (
        output data_in, en_in, sof_in, mode_in,
        input  deleav_data, en_out, sof_out, frame_err
    );
endinterface

// File: rtl/pp_block_deinterleaver_addr_gen.sv
// pp_deint_addr_gen: incremental row-major / column-major address walker
// over a ROWS x COLS matrix, multiplier-free.
//   clk, rst  : clock, synchronous active-high reset
//   step      : advance one element
//   restart   : treat the current position as element 0 (combinational)
//   col_major : 1 = column-major walk, 0 = row-major walk
//   addr      : address of the current element (row*COLS + col)
//   last      : current element is the last of the frame
//   at_start  : registered position is element 0 (ignores restart)
module pp_deint_addr_gen
    import pp_deint_pkg::*;
#(
    parameter int ROWS = 96,
    parameter int COLS = 16,
    parameter int AW   = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          restart,
    input  logic          col_major,
    output logic [AW-1:0] addr,
    output logic          last,
    output logic          at_start
);
    localparam int DEPTH = calc_depth(ROWS, COLS);
    localparam int MAXD  = (ROWS > COLS) ? ROWS : COLS;
    localparam int CW    = $clog2(MAXD + 1);

    logic [CW-1:0] fast_q, slow_q, fast_cur, slow_cur, fast_nxt, slow_nxt;
    logic [CW-1:0] fast_max, slow_max;
    logic [AW-1:0] addr_q, addr_cur, addr_nxt;

    always_comb begin
        fast_cur = restart ? '0 : fast_q;
        slow_cur = restart ? '0 : slow_q;
        addr_cur = restart ? '0 : addr_q;
        fast_max = col_major ? CW'(ROWS - 1) : CW'(COLS - 1);
        slow_max = col_major ? CW'(COLS - 1) : CW'(ROWS - 1);
        last     = (fast_cur == fast_max) && (slow_cur == slow_max);

        fast_nxt = fast_cur + CW'(1);
        slow_nxt = slow_cur;
        addr_nxt = col_major ? addr_cur + AW'(COLS) : addr_cur + AW'(1);

        if (last) begin
            fast_nxt = '0;
            slow_nxt = '0;
            addr_nxt = '0;
        end else if (fast_cur == fast_max) begin
            fast_nxt = '0;
            slow_nxt = slow_cur + CW'(1);
            // Column wrap: the +COLS step folded with -(DEPTH-1) lands on
            // the top of the next column.
            if (col_major)
                addr_nxt = addr_cur - AW'(DEPTH - COLS - 1);
        end
    end

    assign addr     = addr_cur;
    assign at_start = (fast_q == '0) && (slow_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fast_q <= '0;
            slow_q <= '0;
            addr_q <= '0;
        end else if (step) begin
            fast_q <= fast_nxt;
            slow_q <= slow_nxt;
            addr_q <= addr_nxt;
        end else if (restart) begin
            fast_q <= '0;
            slow_q <= '0;
            addr_q <= '0;
        end
    end
endmodule

// File: rtl/pp_block_deinterleaver.sv
// pp_block_deinterleaver: ping-pong row/column block deinterleaver.
// One bank fills while the other is read out in permuted order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pp_block_deinterleaver_if.slave
//              in : data_in, en_in, sof_in, mode_in (0 deint, 1 int)
//              out: deleav_data, en_out, sof_out, frame_err
// Optional feature macro: PP_DEINT_FRAME_ERR_EN (frame_err on resync sof_in);
// when undefined frame_err is tied low.
module pp_block_deinterleaver
    import pp_deint_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int ROWS   = 96,
    parameter int COLS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pp_block_deinterleaver_if.slave bus
);
    localparam int DEPTH  = calc_depth(ROWS, COLS);
    localparam int ADDR_W = calc_addr_w(DEPTH);
    localparam int AW     = ADDR_W - 1;

    // Bank bit is the address MSB; for non-power-of-two DEPTH the top of
    // each half is simply unused.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic          wr_bank, wr_first, wr_order, wr_last, wr_at_start, handoff;
    logic [AW-1:0] wr_addr;
    logic [1:0]    bank_mode;
    logic          pend_q, pend_bank, rd_bank, rd_mode, sel_bank, start_rd;
    logic          rd_step, rd_restart, rd_last, rd_at_start;
    logic [AW-1:0] rd_addr;
    rd_state_t     state_q, state_nxt;
    logic [DATA_W-1:0] dout_q;
    logic          en_q, sof_q;

    always_comb begin
        wr_first = bus.en_in && (bus.sof_in || wr_at_start);
        // The first symbol of a frame sets the walk order directly from
        // mode_in, since the bank's latched mode only updates afterwards.
        wr_order = wr_first ? bus.mode_in : bank_mode[wr_bank];
        handoff  = bus.en_in && wr_last;
    end

    // A resync sof_in restarts the write walk at element 0 of the same bank.
    pp_deint_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_wr_gen (
        .clk       (clk),
        .rst       (rst),
        .step      (bus.en_in),
        .restart   (bus.en_in && bus.sof_in),
        .col_major (wr_order == MODE_DEINT),
        .addr      (wr_addr),
        .last      (wr_last),
        .at_start  (wr_at_start)
    );

    pp_deint_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_rd_gen (
        .clk       (clk),
        .rst       (rst),
        .step      (rd_step),
        .restart   (rd_restart),
        .col_major (rd_mode == MODE_INT),
        .addr      (rd_addr),
        .last      (rd_last),
        .at_start  (rd_at_start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            bank_mode <= '0;
        end else begin
            if (wr_first)
                bank_mode[wr_bank] <= bus.mode_in;
            if (handoff)
                wr_bank <= ~wr_bank;
        end
    end

    // Read FSM: a handoff in the same cycle starts the read immediately,
    // which gives the two-cycle latency and gapless back-to-back frames.
    always_comb begin
        state_nxt  = state_q;
        start_rd   = 1'b0;
        sel_bank   = pend_q ? pend_bank : wr_bank;
        rd_step    = (state_q == RUN);
        rd_restart = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (pend_q || handoff) begin
                    state_nxt = RUN;
                    start_rd  = 1'b1;
                end
            end
            RUN: begin
                if (rd_last) begin
                    if (pend_q || handoff)
                        start_rd = 1'b1;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            pend_bank <= 1'b0;
            rd_bank   <= 1'b0;
            rd_mode   <= MODE_DEINT;
        end else begin
            state_q <= state_nxt;
            if (start_rd) begin
                rd_bank <= sel_bank;
                rd_mode <= bank_mode[sel_bank];
            end
            if (handoff && !(start_rd && !pend_q)) begin
                pend_q    <= 1'b1;
                pend_bank <= wr_bank;
            end else if (start_rd) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.en_in && !rst)
            mem[{wr_bank, wr_addr}] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            en_q   <= 1'b0;
            sof_q  <= 1'b0;
        end else begin
            en_q  <= rd_step;
            sof_q <= rd_step && rd_at_start;
            if (rd_step)
                dout_q <= mem[{rd_bank, rd_addr}];
        end
    end

    assign bus.deleav_data = dout_q;
    assign bus.en_out      = en_q;
    assign bus.sof_out     = sof_q;

`ifdef PP_DEINT_FRAME_ERR_EN
    logic fe_q;
    always_ff @(posedge clk) begin
        if (rst)
            fe_q <= 1'b0;
        else
            fe_q <= bus.en_in && bus.sof_in && !wr_at_start;
    end
    assign bus.frame_err = fe_q;
`else
    assign bus.frame_err = 1'b0;
`endif
endmodule
